// File: rtl/rv32i_mem_pkg.sv
// Shared types and helpers for the RV32I memory arbiter: access sizes,
// arbiter states and the byte-count decode used by both arbiter files.
package rv32i_mem_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } ls_size_e;

    typedef enum logic {
        IDLE   = 1'b0,
        SPLIT2 = 1'b1
    } arb_state_e;

    // Encoding 3 is not a legal size and falls through to a full word.
    function automatic logic [2:0] size_bytes(input ls_size_e s);
        case (s)
            BYTE:    return 3'd1;
            HALF:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_lane_align.sv
// Byte-lane steering for load/store: byte enables and shifted write data for
// the beat being issued, plus extraction of right-aligned load data.
module rv32i_lane_align
    import rv32i_mem_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_beat,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_rd_off,
    input  logic [1:0]  i_rd_size,
    input  logic [63:0] i_rd_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [2:0]  w_n;
    logic [2:0]  w_rd_n;
    logic [3:0]  w_end;
    logic [31:0] w_rd_sh;

    always_comb begin
        w_n   = size_bytes(ls_size_e'(i_size));
        w_end = {2'b00, i_off} + {1'b0, w_n};
        // The second beat only exists when offset + size spills past lane 3.
        if (i_beat) begin
            o_be    = 4'((5'd1 << (w_end - 4'd4)) - 5'd1);
            o_wdata = i_wdata >> (6'd32 - {1'b0, i_off, 3'b000});
        end else begin
            o_be    = 4'(((8'd1 << w_n) - 8'd1) << i_off);
            o_wdata = i_wdata << {i_off, 3'b000};
        end
    end

    always_comb begin
        w_rd_n  = size_bytes(ls_size_e'(i_rd_size));
        w_rd_sh = 32'(i_rd_data >> {i_rd_off, 3'b000});
        case (w_rd_n)
            3'd1:    o_rdata = {24'd0, w_rd_sh[7:0]};
            3'd2:    o_rdata = {16'd0, w_rd_sh[15:0]};
            default: o_rdata = w_rd_sh;
        endcase
    end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Fetch vs load/store arbiter for a single-port word memory. Load/store has
// priority with a starvation guard; word-crossing accesses issue two beats.
module rv32i_mem_arbiter
    import rv32i_mem_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [31:0]       ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [31:0]       ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    arb_state_e        r_state, w_state_nxt;
    logic [SC_W-1:0]   r_sc;
    logic [1:0]        r_cap_off, r_cap_size;
    logic              r_cap_we;
    logic [ADDR_W-1:0] r_cap_addr;
    logic [31:0]       r_cap_wdata, r_beat1;
    logic              r_if_pend, r_ls_pend, r_rd_split;

    logic              w_in_split2, w_starved, w_split;
    logic [2:0]        w_n;
    logic [1:0]        w_al_off, w_al_size;
    logic [31:0]       w_al_wdata, w_al_wsh, w_al_rdata;
    logic [3:0]        w_al_be;
    logic [63:0]       w_rd64;
    logic              w_unused;

    assign w_unused    = ^{if_addr[31:ADDR_W+2], if_addr[1:0], ls_addr[31:ADDR_W+2]};
    assign w_in_split2 = (r_state == SPLIT2);
    assign w_starved   = if_req && (r_sc == SC_W'(STARVE_MAX));
    assign w_n         = size_bytes(ls_size_e'(ls_size));
    assign w_split     = ({2'b00, ls_addr[1:0]} + {1'b0, w_n}) > 4'(WORD_BYTES);

    assign w_al_off   = w_in_split2 ? r_cap_off   : ls_addr[1:0];
    assign w_al_size  = w_in_split2 ? r_cap_size  : ls_size;
    assign w_al_wdata = w_in_split2 ? r_cap_wdata : ls_wdata;
    assign w_rd64     = r_rd_split ? {mem_rdata, r_beat1} : {32'd0, mem_rdata};

    rv32i_lane_align u_align (
        .i_off     (w_al_off),
        .i_size    (w_al_size),
        .i_beat    (w_in_split2),
        .i_wdata   (w_al_wdata),
        .i_rd_off  (r_cap_off),
        .i_rd_size (r_cap_size),
        .i_rd_data (w_rd64),
        .o_be      (w_al_be),
        .o_wdata   (w_al_wsh),
        .o_rdata   (w_al_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Gating with rst_n keeps every output quiet while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        if_gnt      = 1'b0;
        ls_gnt      = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_be      = 4'h0;
        mem_addr    = '0;
        mem_wdata   = 32'd0;
        if (rst_n) begin
            if (w_in_split2) begin
                mem_en      = 1'b1;
                mem_we      = r_cap_we;
                mem_be      = w_al_be;
                mem_addr    = r_cap_addr;
                mem_wdata   = r_cap_we ? w_al_wsh : 32'd0;
                w_state_nxt = IDLE;
            end else if (ls_req && !w_starved) begin
                ls_gnt    = 1'b1;
                mem_en    = 1'b1;
                mem_we    = ls_we;
                mem_be    = w_al_be;
                mem_addr  = ls_addr[ADDR_W+1:2];
                mem_wdata = ls_we ? w_al_wsh : 32'd0;
                if (w_split) w_state_nxt = SPLIT2;
            end else if (if_req) begin
                if_gnt   = 1'b1;
                mem_en   = 1'b1;
                mem_be   = 4'hF;
                mem_addr = if_addr[ADDR_W+1:2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sc       <= '0;
            r_if_pend  <= 1'b0;
            r_ls_pend  <= 1'b0;
            r_rd_split <= 1'b0;
        end else begin
            if (!if_req || if_gnt)                r_sc <= '0;
            else if (r_sc != SC_W'(STARVE_MAX))   r_sc <= r_sc + 1'b1;
            r_if_pend  <= if_gnt;
            r_ls_pend  <= (ls_gnt && !ls_we && !w_split) || (w_in_split2 && !r_cap_we);
            r_rd_split <= w_in_split2 && !r_cap_we;
        end
    end

    // Capture is refreshed on every load/store grant so a single-beat load's
    // response cycle also finds its offset and size here.
    always_ff @(posedge clk) begin
        if (ls_gnt) begin
            r_cap_off   <= ls_addr[1:0];
            r_cap_size  <= ls_size;
            r_cap_we    <= ls_we;
            r_cap_addr  <= ls_addr[ADDR_W+1:2] + ADDR_W'(1);
            r_cap_wdata <= ls_wdata;
        end
        if (w_in_split2) r_beat1 <= mem_rdata;
    end

    assign if_rvalid = r_if_pend;
    assign if_rdata  = r_if_pend ? mem_rdata : 32'd0;
    assign ls_rvalid = r_ls_pend;
    assign ls_rdata  = r_ls_pend ? w_al_rdata : 32'd0;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Bench for rv32i_mem_arbiter: byte-level reference model checked every cycle
// plus hand-computed expectations for the key directed scenarios.
module tb_rv32i_mem_arbiter;

    localparam int AW   = 15;
    localparam int SMAX = 4;

    logic          clk, rst_n;
    logic          if_req, if_gnt, if_rvalid;
    logic [31:0]   if_addr, if_rdata;
    logic          ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [1:0]    ls_size;
    logic [31:0]   ls_addr, ls_wdata, ls_rdata;
    logic          mem_en, mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    logic [31:0] mem     [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];

    int n_cmp = 0;
    int n_bad = 0;

    rv32i_mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] bmask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= (mem[mem_addr] & ~bmask(mem_be)) | (mem_wdata & bmask(mem_be));
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Byte-by-byte view of one load/store: which word and lane each byte lands
    // in, and the load result assembled from the reference memory.
    task automatic ls_model(input logic [31:0] a, input logic [1:0] sz, input logic we,
                            input logic [31:0] wd, output int nb,
                            output logic [AW-1:0] w0, output logic [AW-1:0] w1,
                            output logic [3:0] b0, output logic [3:0] b1,
                            output logic [31:0] d0, output logic [31:0] d1,
                            output logic [31:0] rd);
        int n, ln;
        logic [31:0] ba;
        logic [AW-1:0] w;
        n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        nb = 1; w0 = a[AW+1:2]; w1 = w0;
        b0 = 4'h0; b1 = 4'h0; d0 = 32'd0; d1 = 32'd0; rd = 32'd0;
        for (int k = 0; k < n; k++) begin
            ba = a + 32'(k);
            w  = ba[AW+1:2];
            ln = int'(ba[1:0]);
            if (w != w0) begin
                nb = 2; w1 = w; b1[ln] = 1'b1; d1[8*ln +: 8] = wd[8*k +: 8];
            end else begin
                b0[ln] = 1'b1; d0[8*ln +: 8] = wd[8*k +: 8];
            end
            if (we) ref_mem[w][8*ln +: 8] = wd[8*k +: 8];
            else    rd[8*k +: 8] = ref_mem[w][8*ln +: 8];
        end
    endtask

    int            m_cyc = 0;
    int            m_sc, slot, nb;
    logic          m_pend, p_we;
    logic [3:0]    p_be, x_be, b0, b1;
    logic [AW-1:0] p_addr, x_addr, a0, a1;
    logic [31:0]   p_wd, x_wd, d0, d1, rd;
    logic          x_if, x_ls, x_en, x_we;
    logic          e_if_v [8];
    logic          e_ls_v [8];
    logic [31:0]   e_if_d [8];
    logic [31:0]   e_ls_d [8];

    always @(negedge clk) begin
        slot = m_cyc % 8;
        if (!rst_n) begin
            m_sc = 0; m_pend = 1'b0;
            for (int i = 0; i < 8; i++) begin e_if_v[i] = 1'b0; e_ls_v[i] = 1'b0; end
            chk("rst_gnts",   32'({if_gnt, ls_gnt, mem_en, mem_we}), 32'd0);
            chk("rst_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
            chk("rst_be_addr", 32'({mem_be, mem_addr}), 32'd0);
            chk("rst_data",   mem_wdata | if_rdata | ls_rdata, 32'd0);
        end else begin
            chk("if_rvalid", 32'(if_rvalid), 32'(e_if_v[slot]));
            if (e_if_v[slot]) chk("if_rdata", if_rdata, e_if_d[slot]);
            chk("ls_rvalid", 32'(ls_rvalid), 32'(e_ls_v[slot]));
            if (e_ls_v[slot]) chk("ls_rdata", ls_rdata, e_ls_d[slot]);
            e_if_v[slot] = 1'b0; e_ls_v[slot] = 1'b0;
            x_if = 1'b0; x_ls = 1'b0; x_en = 1'b0; x_we = 1'b0;
            x_be = 4'h0; x_addr = '0; x_wd = 32'd0;
            if (m_pend) begin
                x_en = 1'b1; x_we = p_we; x_be = p_be; x_addr = p_addr; x_wd = p_wd;
                m_pend = 1'b0;
            end else if (ls_req && !(if_req && m_sc == SMAX)) begin
                ls_model(ls_addr, ls_size, ls_we, ls_wdata, nb, a0, a1, b0, b1, d0, d1, rd);
                x_ls = 1'b1; x_en = 1'b1; x_we = ls_we; x_be = b0; x_addr = a0; x_wd = d0;
                if (nb == 2) begin
                    m_pend = 1'b1; p_we = ls_we; p_be = b1; p_addr = a1; p_wd = d1;
                end
                if (!ls_we) begin
                    e_ls_v[(m_cyc + nb) % 8] = 1'b1;
                    e_ls_d[(m_cyc + nb) % 8] = rd;
                end
            end else if (if_req) begin
                x_if = 1'b1; x_en = 1'b1; x_be = 4'hF; x_addr = if_addr[AW+1:2];
                e_if_v[(m_cyc + 1) % 8] = 1'b1;
                e_if_d[(m_cyc + 1) % 8] = ref_mem[x_addr];
            end
            chk("if_gnt", 32'(if_gnt), 32'(x_if));
            chk("ls_gnt", 32'(ls_gnt), 32'(x_ls));
            chk("mem_en", 32'(mem_en), 32'(x_en));
            if (x_en) begin
                chk("mem_we",   32'(mem_we), 32'(x_we));
                chk("mem_be",   32'(mem_be), 32'(x_be));
                chk("mem_addr", 32'(mem_addr), 32'(x_addr));
                if (x_we) chk("mem_wdata", mem_wdata & bmask(x_be), x_wd);
            end
            if (if_req && !x_if) m_sc = (m_sc < SMAX) ? m_sc + 1 : m_sc;
            else                 m_sc = 0;
        end
        m_cyc++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
                         input logic [1:0] lsz, input logic [31:0] la, input logic [31:0] ld);
        if_req = ir; if_addr = ia; ls_req = lr; ls_we = lw;
        ls_size = lsz; ls_addr = la; ls_wdata = ld;
    endtask

    task automatic ls_op(input logic lw, input logic [1:0] lsz, input logic [31:0] la,
                         input logic [31:0] ld);
        int k;
        ls_req = 1'b1; ls_we = lw; ls_size = lsz; ls_addr = la; ls_wdata = ld;
        k = 0;
        #2;
        while (!ls_gnt && k < 10) begin tick; #2; k++; end
        chk("ls_gnt_wait", 32'(ls_gnt), 32'd1);
        tick;
        ls_req = 1'b0;
    endtask

    logic [1:0] gl [6];

    initial begin
        rst_n = 1'b0;
        mem_rdata = 32'd0;
        drive(1'b1, 32'h100, 1'b1, 1'b0, 2'd2, 32'h10, 32'd0);
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 32'(i) * 32'h0100_0193 + 32'h0123_4567;
        ref_mem[0] = 32'h8011_2233;
        ref_mem[1] = 32'hDDCC_BBAA;
        ref_mem[2] = 32'h4433_2211;
        for (int i = 0; i < (1 << AW); i++) mem[i] = ref_mem[i];
        #3;
        chk("lit_rst_quiet", 32'({if_gnt, ls_gnt, mem_en}), 32'd0);
        tick; tick;
        rst_n = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        tick;

        // Both requesting: four load/store wins, then fetch breaks through.
        drive(1'b1, 32'h100, 1'b1, 1'b0, 2'd2, 32'h10, 32'd0);
        for (int i = 0; i < 6; i++) begin #2; gl[i] = {if_gnt, ls_gnt}; tick; end
        drive(1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        tick; tick;
        for (int i = 0; i < 6; i++)
            chk($sformatf("lit_starve_c%0d", i), 32'(gl[i]), (i == 4) ? 32'd2 : 32'd1);

        // Split load word at 0x6.
        drive(1'b0, 32'd0, 1'b1, 1'b0, 2'd2, 32'h6, 32'd0);
        #2; chk("lit_lw6_b1_addr", 32'(mem_addr), 32'd1); chk("lit_lw6_b1_be", 32'(mem_be), 32'hC);
        tick; ls_req = 1'b0;
        #2; chk("lit_lw6_b2_addr", 32'(mem_addr), 32'd2); chk("lit_lw6_b2_be", 32'(mem_be), 32'h3);
        chk("lit_lw6_b2_nognt", 32'(ls_gnt), 32'd0);
        tick;
        #2; chk("lit_lw6_rvalid", 32'(ls_rvalid), 32'd1); chk("lit_lw6_rdata", ls_rdata, 32'h2211_DDCC);
        tick;

        // Split store half 0xBEEF at 0x7.
        drive(1'b0, 32'd0, 1'b1, 1'b1, 2'd1, 32'h7, 32'h0000_BEEF);
        #2; chk("lit_sh7_b1_be", 32'(mem_be), 32'h8); chk("lit_sh7_b1_wd", 32'(mem_wdata[31:24]), 32'hEF);
        chk("lit_sh7_b1_addr", 32'(mem_addr), 32'd1);
        tick; ls_req = 1'b0;
        #2; chk("lit_sh7_b2_be", 32'(mem_be), 32'h1); chk("lit_sh7_b2_wd", 32'(mem_wdata[7:0]), 32'hBE);
        chk("lit_sh7_b2_addr", 32'(mem_addr), 32'd2);
        tick;

        // Load byte at 0x3: single beat.
        drive(1'b0, 32'd0, 1'b1, 1'b0, 2'd0, 32'h3, 32'd0);
        #2; chk("lit_lb3_gnt", 32'(ls_gnt), 32'd1);
        tick; ls_req = 1'b0;
        #2; chk("lit_lb3_rvalid", 32'(ls_rvalid), 32'd1); chk("lit_lb3_rdata", ls_rdata, 32'h0000_0080);
        chk("lit_lb3_nosplit", 32'(mem_en), 32'd0);
        tick;

        // Word load at the last word wraps to word 0.
        drive(1'b0, 32'd0, 1'b1, 1'b0, 2'd2, 32'h0001_FFFD, 32'd0);
        #2; chk("lit_wrap_b1_addr", 32'(mem_addr), 32'h7FFF); chk("lit_wrap_b1_be", 32'(mem_be), 32'hE);
        tick; ls_req = 1'b0;
        #2; chk("lit_wrap_b2_addr", 32'(mem_addr), 32'd0); chk("lit_wrap_b2_be", 32'(mem_be), 32'h1);
        tick; tick;

        // Mixed traffic with fetch requesting throughout.
        if_req = 1'b1; if_addr = 32'h40;
        ls_op(1'b1, 2'd2, 32'h22, 32'h1122_3344);
        ls_op(1'b0, 2'd2, 32'h22, 32'd0);
        ls_op(1'b0, 2'd1, 32'h5,  32'd0);
        ls_op(1'b1, 2'd0, 32'h31, 32'h0000_00A5);
        ls_op(1'b0, 2'd1, 32'h33, 32'd0);
        ls_op(1'b1, 2'd3, 32'h50, 32'hCAFE_F00D);
        ls_op(1'b0, 2'd3, 32'h50, 32'd0);
        ls_op(1'b0, 2'd1, 32'h31, 32'd0);
        ls_op(1'b0, 2'd2, 32'h57, 32'd0);
        if_req = 1'b0;
        tick; tick; tick;

        // Reset in the second beat of a split load.
        drive(1'b0, 32'd0, 1'b1, 1'b0, 2'd2, 32'h46, 32'd0);
        #2; chk("lit_rstsplit_gnt", 32'(ls_gnt), 32'd1);
        tick;
        drive(1'b1, 32'h80, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        #2; rst_n = 1'b0;
        #1; chk("lit_rstsplit_quiet", 32'({mem_en, ls_gnt, if_gnt, ls_rvalid}), 32'd0);
        tick;
        rst_n = 1'b1;
        #2; chk("lit_rel_if_gnt", 32'(if_gnt), 32'd1); chk("lit_rel_no_rvalid", 32'(ls_rvalid), 32'd0);
        tick;
        if_req = 1'b0;
        #2; chk("lit_rel_if_rvalid", 32'(if_rvalid), 32'd1); chk("lit_rel_no_rvalid2", 32'(ls_rvalid), 32'd0);
        tick; tick; tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
